// File: rtl/width_convert_lo2hi_rdy_val_if.sv
// -----------------------------------------------------------------------------
// width_convert_lo2hi_rdy_val_if
//   Bundles the narrow upstream (tx_*) and wide downstream (bx_*, rx_rdy)
//   ready/valid signals of the lo2hi packer.
//
//   slave  : the packer's view (consumes tx_*, rx_rdy; produces bx_*)
//   master : the environment's view (produces tx_*, rx_rdy; consumes bx_*)
//
//   tx_valid / tx_data[TX_DW] / tx_last : upstream beat
//   bx_rdy                              : packer can take a beat this cycle
//   bx_valid / bx_data[RX_DW]           : packed word
//   bx_keep[RATIO] / bx_last            : lane-valid mask, end-of-packet flag
//   rx_rdy                              : downstream takes the word this cycle
// -----------------------------------------------------------------------------
interface width_convert_lo2hi_rdy_val_if #(
    parameter int TX_DW = 8,
    parameter int RX_DW = 16
);
    localparam int RATIO = RX_DW / TX_DW;

    logic               tx_valid;
    logic [TX_DW-1:0]   tx_data;
    logic               tx_last;
    logic               bx_rdy;
    logic               bx_valid;
    logic [RX_DW-1:0]   bx_data;
    logic [RATIO-1:0]   bx_keep;
    logic               bx_last;
    logic               rx_rdy;

    modport slave (
        input  tx_valid, tx_data, tx_last, rx_rdy,
        output bx_rdy, bx_valid, bx_data, bx_keep, bx_last
    );

    modport master (
        output tx_valid, tx_data, tx_last, rx_rdy,
        input  bx_rdy, bx_valid, bx_data, bx_keep, bx_last
    );
endinterface

// File: rtl/width_convert_lo2hi_rdy_val.sv
// -----------------------------------------------------------------------------
// width_convert_lo2hi_rdy_val
//   Narrow-to-wide ready/valid packer. Collects RATIO = RX_DW/TX_DW upstream
//   beats into one downstream word, first beat in the least-significant lane.
//   A beat with tx_last flushes a partial word early; unfilled lanes are zero
//   and cleared in bx_keep.
//
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : slave modport of width_convert_lo2hi_rdy_val_if
//           (tx_valid/tx_data/tx_last in, bx_rdy out,
//            bx_valid/bx_data/bx_keep/bx_last out, rx_rdy in)
// -----------------------------------------------------------------------------
module width_convert_lo2hi_rdy_val #(
    parameter int TX_DW = 8,
    parameter int RX_DW = 16
) (
    input  logic                          clk,
    input  logic                          rst_b,
    width_convert_lo2hi_rdy_val_if.slave  bus
);
    localparam int RATIO = RX_DW / TX_DW;
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    generate
        if (((RX_DW % TX_DW) != 0) || (RATIO < 2)) begin : g_bad_params
            $error("width_convert_lo2hi_rdy_val: RX_DW (%0d) must be a multiple >= 2 of TX_DW (%0d)",
                   RX_DW, TX_DW);
        end
    endgenerate

    // Word built from a completing beat: lanes below 'lane' come from the
    // accumulator, lane 'lane' is the new beat, lanes above are zero.
    function automatic logic [RX_DW-1:0] pack_word(
        input logic [RX_DW-1:0] acc_in,
        input logic [TX_DW-1:0] beat,
        input logic [CNT_W-1:0] lane
    );
        logic [RX_DW-1:0] w;
        w = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(lane)) begin
                w[k*TX_DW +: TX_DW] = acc_in[k*TX_DW +: TX_DW];
            end else if (k == int'(lane)) begin
                w[k*TX_DW +: TX_DW] = beat;
            end
        end
        return w;
    endfunction

    function automatic logic [RATIO-1:0] keep_mask(input logic [CNT_W-1:0] lane);
        logic [RATIO-1:0] m;
        m = '0;
        for (int k = 0; k < RATIO; k++) begin
            m[k] = (k <= int'(lane));
        end
        return m;
    endfunction

    // Accumulator and lane counter (cnt doubles as the FILL_k state).
    logic [RX_DW-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // Output register.
    logic               vld_p0, vld_nxt;
    logic [RX_DW-1:0]   data_p0, data_nxt;
    logic [RATIO-1:0]   keep_p0, keep_nxt;
    logic               last_p0, last_nxt;

    logic               rdy;
    logic               acc_fire;
    logic               out_fire;
    logic               complete;

    // A held word blocks filling unless it drains on this same edge.
    assign rdy      = !vld_p0 || bus.rx_rdy;
    assign acc_fire = bus.tx_valid && rdy;
    assign out_fire = vld_p0 && bus.rx_rdy;
    assign complete = acc_fire && ((cnt == CNT_W'(RATIO - 1)) || bus.tx_last);

    always_comb begin
        acc_nxt  = acc;
        cnt_nxt  = cnt;
        vld_nxt  = vld_p0;
        data_nxt = data_p0;
        keep_nxt = keep_p0;
        last_nxt = last_p0;

        if (out_fire) begin
            vld_nxt = 1'b0;
        end

        if (complete) begin
            data_nxt = pack_word(acc, bus.tx_data, cnt);
            keep_nxt = keep_mask(cnt);
            last_nxt = bus.tx_last;
            vld_nxt  = 1'b1;
            acc_nxt  = '0;
            cnt_nxt  = '0;
        end else if (acc_fire) begin
            acc_nxt[int'(cnt)*TX_DW +: TX_DW] = bus.tx_data;
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // ---- stage p0: accumulator, counter and output register ----
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc     <= '0;
            cnt     <= '0;
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            vld_p0  <= vld_nxt;
            data_p0 <= data_nxt;
            keep_p0 <= keep_nxt;
            last_p0 <= last_nxt;
        end
    end

    assign bus.bx_rdy   = rdy;
    assign bus.bx_valid = vld_p0;
    assign bus.bx_data  = data_p0;
    assign bus.bx_keep  = keep_p0;
    assign bus.bx_last  = last_p0;

endmodule
